vx_perf_memsys_reader: RTL
==========================

// Module: vx_perf_memsys_reader
// PURPOSE
//  Consumer (slave-side) end of VX_perf_memsys_if: serves 32-bit CSR-style reads of the
//  memory-system perf counters to the core CSR unit via a valid/ready request/response pair.
//  A lo-word read snapshots the full counter so the following hi-word read is coherent
//  (no tearing while the counter keeps running). Sits between the memsys counters and the CSR unit.
// PARAMETERS
//  PERF_CTR_BITS  44  width of every counter in the interface (1..64); zero-extended to 64
//  NUM_CTRS       23  number of valid counter indices (fixed map below)
// PORTS
//  clk             in   1     clock
//  reset           in   1     synchronous, active-high reset
//  perf_memsys_if  in   intf  VX_perf_memsys_if.slave; 23 counters x PERF_CTR_BITS
//  req_valid       in   1     read request valid
//  req_ready       out  1     request accepted when req_valid && req_ready
//  req_idx         in   5     counter index
//  req_hi          in   1     0 = bits[31:0], 1 = bits[63:32]
//  resp_valid      out  1     response valid
//  resp_ready      in   1     response consumed when resp_valid && resp_ready
//  resp_data       out  32    counter word
//  resp_err        out  1     1 = index out of range
// BEHAVIOUR
//  Index map: 0 icache_reads,1 icache_read_misses,2 icache_pipe_stalls,3 icache_crsp_stalls,
//   4 dcache_reads,5 dcache_writes,6 dcache_read_misses,7 dcache_write_misses,8 dcache_bank_stalls,
//   9 dcache_mshr_stalls,10 dcache_pipe_stalls,11 dcache_crsp_stalls,12 dcache_prefetch_requests,
//   13 dcache_prefetched_blocks,14 dcache_unused_prefetched_blocks,15 dcache_late_prefetches,
//   16 smem_reads,17 smem_writes,18 smem_bank_stalls,19 mem_reads,20 mem_writes,21 mem_stalls,
//   22 mem_latency; 23..31 invalid.
//  Reset: resp_valid=0, resp_data=0, resp_err=0, snap_valid=0, snap_idx=0, snap_val=0; FSM=IDLE.
//  FSM: IDLE (no response held) / RESP (response held).
//   IDLE: req_ready=1; accept -> RESP.
//   RESP: req_ready=resp_ready; on resp_ready: new accept same cycle -> stay RESP, else -> IDLE.
//  Latency: response registered; resp_valid rises the cycle after accept; back-to-back
//   accepts sustain 1 read/cycle while resp_ready=1.
//  resp_data/resp_err stable while resp_valid && !resp_ready.
//  Counter value C = zero-extend(counter[req_idx]) to 64 bits, sampled in accept cycle.
//  Lo read (req_hi=0, valid idx): resp_data=C[31:0]; snap_val<=C, snap_idx<=req_idx, snap_valid<=1.
//  Hi read (req_hi=1, valid idx): if snap_valid && snap_idx==req_idx -> resp_data=snap_val[63:32],
//   else resp_data=C[63:32]; either way snap_valid<=0.
//  PERF_CTR_BITS<=32: hi word always 0.
//  Invalid idx: resp_data=0, resp_err=1, snapshot state unchanged.
//  Lo read of another index overwrites the snapshot (single slot).
//  Reset mid-transaction: held response dropped, snapshot discarded, next cycle IDLE.
// TESTING
//  idx 4 = 0x12_3456_789A, lo then hi -> resp 0x3456789A, then 0x00000012.
//  idx 4 lo at 0x0_FFFF_FFFF; counter -> 0x1_0000_0005 before hi -> hi returns 0x0 (snapshot).
//  hi idx 6 with no prior lo, counter 0x7_0000_0000 -> 0x00000007; lo 6 then lo 7, hi 6 -> live value.
//  req_idx=23 -> resp_err=1, resp_data=0; then hi on snapshotted idx still returns snapshot.
//  resp_ready held 0 for 3 cycles -> req_ready=0, resp_data stable; then 4 back-to-back reads at
//   resp_ready=1 -> 4 responses on 4 consecutive cycles, in order.
//  reset asserted with resp_valid=1 -> resp_valid=0 next cycle; following hi read returns live value.

Source files
------------

// File: rtl/vx_perf_memsys_reader_if.sv
// Memory-system perf counter bundle: producer drives through master, reader samples through slave.
interface vx_perf_memsys_if #(
    parameter int unsigned PERF_CTR_BITS = 44
);
    logic [PERF_CTR_BITS-1:0] icache_reads;
    logic [PERF_CTR_BITS-1:0] icache_read_misses;
    logic [PERF_CTR_BITS-1:0] icache_pipe_stalls;
    logic [PERF_CTR_BITS-1:0] icache_crsp_stalls;
    logic [PERF_CTR_BITS-1:0] dcache_reads;
    logic [PERF_CTR_BITS-1:0] dcache_writes;
    logic [PERF_CTR_BITS-1:0] dcache_read_misses;
    logic [PERF_CTR_BITS-1:0] dcache_write_misses;
    logic [PERF_CTR_BITS-1:0] dcache_bank_stalls;
    logic [PERF_CTR_BITS-1:0] dcache_mshr_stalls;
    logic [PERF_CTR_BITS-1:0] dcache_pipe_stalls;
    logic [PERF_CTR_BITS-1:0] dcache_crsp_stalls;
    logic [PERF_CTR_BITS-1:0] dcache_prefetch_requests;
    logic [PERF_CTR_BITS-1:0] dcache_prefetched_blocks;
    logic [PERF_CTR_BITS-1:0] dcache_unused_prefetched_blocks;
    logic [PERF_CTR_BITS-1:0] dcache_late_prefetches;
    logic [PERF_CTR_BITS-1:0] smem_reads;
    logic [PERF_CTR_BITS-1:0] smem_writes;
    logic [PERF_CTR_BITS-1:0] smem_bank_stalls;
    logic [PERF_CTR_BITS-1:0] mem_reads;
    logic [PERF_CTR_BITS-1:0] mem_writes;
    logic [PERF_CTR_BITS-1:0] mem_stalls;
    logic [PERF_CTR_BITS-1:0] mem_latency;

    modport master (
        output icache_reads, icache_read_misses, icache_pipe_stalls, icache_crsp_stalls,
        output dcache_reads, dcache_writes, dcache_read_misses, dcache_write_misses,
        output dcache_bank_stalls, dcache_mshr_stalls, dcache_pipe_stalls, dcache_crsp_stalls,
        output dcache_prefetch_requests, dcache_prefetched_blocks,
        output dcache_unused_prefetched_blocks, dcache_late_prefetches,
        output smem_reads, smem_writes, smem_bank_stalls,
        output mem_reads, mem_writes, mem_stalls, mem_latency
    );

    modport slave (
        input icache_reads, icache_read_misses, icache_pipe_stalls, icache_crsp_stalls,
        input dcache_reads, dcache_writes, dcache_read_misses, dcache_write_misses,
        input dcache_bank_stalls, dcache_mshr_stalls, dcache_pipe_stalls, dcache_crsp_stalls,
        input dcache_prefetch_requests, dcache_prefetched_blocks,
        input dcache_unused_prefetched_blocks, dcache_late_prefetches,
        input smem_reads, smem_writes, smem_bank_stalls,
        input mem_reads, mem_writes, mem_stalls, mem_latency
    );
endinterface

// File: rtl/vx_perf_memsys_reader.sv
// CSR-side reader of the memory-system perf counters. 32-bit word reads over a valid/ready
// request/response pair; a lo-word read snapshots the whole counter so the matching hi-word
// read returns a coherent value while the counter keeps running.
module vx_perf_memsys_reader #(
    parameter int unsigned PERF_CTR_BITS = 44,
    parameter int unsigned NUM_CTRS      = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    vx_perf_memsys_if.slave        perf_memsys_if,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [4:0]             req_idx_i,
    input  logic                   req_hi_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [31:0]            resp_data_o,
    output logic                   resp_err_o
);

    // Clears any bits above the counter width so narrow counters read back with a zero hi word.
    localparam logic [63:0] CtrMask = (PERF_CTR_BITS >= 64) ? '1 :
                                      ((64'd1 << PERF_CTR_BITS) - 64'd1);

    typedef enum logic {StIdle, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic        snap_valid_q, snap_valid_d;
    logic [4:0]  snap_idx_q, snap_idx_d;
    logic [63:0] snap_val_q, snap_val_d;

    logic        req_fire;
    logic        idx_in_map;
    logic        idx_valid;
    logic        snap_hit;
    logic [63:0] ctr_raw;
    logic [63:0] ctr_val;

    // Select the addressed counter and zero-extend it to 64 bits.
    always_comb begin
        ctr_raw    = '0;
        idx_in_map = 1'b1;
        case (req_idx_i)
            5'd0:    ctr_raw = 64'(perf_memsys_if.icache_reads);
            5'd1:    ctr_raw = 64'(perf_memsys_if.icache_read_misses);
            5'd2:    ctr_raw = 64'(perf_memsys_if.icache_pipe_stalls);
            5'd3:    ctr_raw = 64'(perf_memsys_if.icache_crsp_stalls);
            5'd4:    ctr_raw = 64'(perf_memsys_if.dcache_reads);
            5'd5:    ctr_raw = 64'(perf_memsys_if.dcache_writes);
            5'd6:    ctr_raw = 64'(perf_memsys_if.dcache_read_misses);
            5'd7:    ctr_raw = 64'(perf_memsys_if.dcache_write_misses);
            5'd8:    ctr_raw = 64'(perf_memsys_if.dcache_bank_stalls);
            5'd9:    ctr_raw = 64'(perf_memsys_if.dcache_mshr_stalls);
            5'd10:   ctr_raw = 64'(perf_memsys_if.dcache_pipe_stalls);
            5'd11:   ctr_raw = 64'(perf_memsys_if.dcache_crsp_stalls);
            5'd12:   ctr_raw = 64'(perf_memsys_if.dcache_prefetch_requests);
            5'd13:   ctr_raw = 64'(perf_memsys_if.dcache_prefetched_blocks);
            5'd14:   ctr_raw = 64'(perf_memsys_if.dcache_unused_prefetched_blocks);
            5'd15:   ctr_raw = 64'(perf_memsys_if.dcache_late_prefetches);
            5'd16:   ctr_raw = 64'(perf_memsys_if.smem_reads);
            5'd17:   ctr_raw = 64'(perf_memsys_if.smem_writes);
            5'd18:   ctr_raw = 64'(perf_memsys_if.smem_bank_stalls);
            5'd19:   ctr_raw = 64'(perf_memsys_if.mem_reads);
            5'd20:   ctr_raw = 64'(perf_memsys_if.mem_writes);
            5'd21:   ctr_raw = 64'(perf_memsys_if.mem_stalls);
            5'd22:   ctr_raw = 64'(perf_memsys_if.mem_latency);
            default: idx_in_map = 1'b0;
        endcase
    end

    assign ctr_val   = ctr_raw & CtrMask;
    assign idx_valid = idx_in_map && (32'(req_idx_i) < NUM_CTRS);
    assign snap_hit  = snap_valid_q && (snap_idx_q == req_idx_i);
    assign req_fire  = req_valid_i && req_ready_o;

    // Handshake FSM: a single response slot, refilled in the same cycle it drains.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b1;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                req_ready_o = resp_ready_i;
                if (resp_ready_i) begin
                    state_d = req_valid_i ? StResp : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Response word and snapshot update on an accepted request; held otherwise.
    always_comb begin
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        snap_valid_d = snap_valid_q;
        snap_idx_d   = snap_idx_q;
        snap_val_d   = snap_val_q;
        if (req_fire) begin
            if (!idx_valid) begin
                // Invalid index leaves the snapshot untouched.
                resp_data_d = '0;
                resp_err_d  = 1'b1;
            end else if (!req_hi_i) begin
                resp_data_d  = ctr_val[31:0];
                resp_err_d   = 1'b0;
                snap_valid_d = 1'b1;
                snap_idx_d   = req_idx_i;
                snap_val_d   = ctr_val;
            end else begin
                resp_data_d  = snap_hit ? snap_val_q[63:32] : ctr_val[63:32];
                resp_err_d   = 1'b0;
                snap_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_idx_q   <= '0;
            snap_val_q   <= '0;
        end else begin
            state_q      <= state_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            snap_valid_q <= snap_valid_d;
            snap_idx_q   <= snap_idx_d;
            snap_val_q   <= snap_val_d;
        end
    end

    assign resp_valid_o = (state_q == StResp);
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;

endmodule
